spu_gbuf_responder: RTL

- Global feature-map buffer responder serving the SPU gbuf master port (LN/softmax style engines: ren/raddr → rdata, wen/waddr/wdata).
- Also serves a host/DMA load-dump port with valid/ready handshake.
- 1R1W storage with fixed read latency RLATENCY.
- Ownership state machine gives the SPU exclusive, stall-free access between spu_start and spu_end.

---
 rtl/spu_gbuf_pkg.sv | 25 ++
 rtl/spu_gbuf_responder_if.sv | 35 +++
 rtl/spu_gbuf_rd_pipe.sv | 66 ++++++
 rtl/spu_gbuf_responder.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/spu_gbuf_pkg.sv
// Shared types and constants for the SPU global feature-map buffer responder.
package spu_gbuf_pkg;

    // Deepest supported read pipeline.
    localparam int unsigned RLATENCY_MAX = 4;
    // Drain counter holds RLATENCY-1, at most RLATENCY_MAX-1.
    localparam int unsigned DRAIN_CNT_W  = 2;

    // Read-pipe tag: who issued the read.
    localparam logic TAG_SPU  = 1'b0;
    localparam logic TAG_HOST = 1'b1;

    // Memory ownership.
    typedef enum logic [1:0] {
        ST_HOST    = 2'b00,
        ST_SPU_ACT = 2'b01,
        ST_DRAIN   = 2'b10
    } gbuf_state_e;

    // True when a (zero-extended) address falls inside the implemented words.
    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
        return (addr < depth);
    endfunction

endpackage

// File: rtl/spu_gbuf_responder_if.sv
// SPU gbuf master port plus host load/dump port of the gbuf responder.
interface spu_gbuf_responder_if #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32
);
    // SPU port
    logic                  spu_gbuf_ren;
    logic [ADDR_WIDTH-1:0] spu_gbuf_raddr;
    logic [DATA_WIDTH-1:0] spu_gbuf_rdata;
    logic                  spu_gbuf_wen;
    logic [ADDR_WIDTH-1:0] spu_gbuf_waddr;
    logic [DATA_WIDTH-1:0] spu_gbuf_wdata;

    // Host / DMA port
    logic                  host_req_valid;
    logic                  host_req_ready;
    logic                  host_req_we;
    logic [ADDR_WIDTH-1:0] host_req_addr;
    logic [DATA_WIDTH-1:0] host_req_wdata;
    logic                  host_rsp_valid;
    logic [DATA_WIDTH-1:0] host_rsp_rdata;

    modport master (
        output spu_gbuf_ren, spu_gbuf_raddr, spu_gbuf_wen, spu_gbuf_waddr, spu_gbuf_wdata,
        output host_req_valid, host_req_we, host_req_addr, host_req_wdata,
        input  spu_gbuf_rdata, host_req_ready, host_rsp_valid, host_rsp_rdata
    );

    modport slave (
        input  spu_gbuf_ren, spu_gbuf_raddr, spu_gbuf_wen, spu_gbuf_waddr, spu_gbuf_wdata,
        input  host_req_valid, host_req_we, host_req_addr, host_req_wdata,
        output spu_gbuf_rdata, host_req_ready, host_rsp_valid, host_rsp_rdata
    );

endinterface

// File: rtl/spu_gbuf_rd_pipe.sv
// RLATENCY-deep valid/tag/data shift pipeline carrying read results to their port.
// land_* is what enters the last stage this cycle; out_* is the last stage itself.
module spu_gbuf_rd_pipe #(
    parameter int unsigned RLATENCY   = 1,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  core_clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic                  in_tag,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  land_valid,
    output logic                  land_tag,
    output logic [DATA_WIDTH-1:0] land_data,
    output logic                  out_valid,
    output logic                  out_tag,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic [RLATENCY-1:0]   valid_q, valid_d;
    logic [RLATENCY-1:0]   tag_q,   tag_d;
    logic [DATA_WIDTH-1:0] data_q [RLATENCY];
    logic [DATA_WIDTH-1:0] data_d [RLATENCY];

    // Stage 0 takes the issue-cycle read; every other stage takes its predecessor.
    always_comb begin
        valid_d = '0;
        tag_d   = '0;
        for (int i = 0; i < int'(RLATENCY); i++) begin
            data_d[i] = '0;
        end
        valid_d[0] = in_valid;
        tag_d[0]   = in_tag;
        data_d[0]  = in_data;
        for (int i = 1; i < int'(RLATENCY); i++) begin
            valid_d[i] = valid_q[i-1];
            tag_d[i]   = tag_q[i-1];
            data_d[i]  = data_q[i-1];
        end
    end

    // Stage registers; reset drops everything in flight.
    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            tag_q   <= '0;
            for (int i = 0; i < int'(RLATENCY); i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            for (int i = 0; i < int'(RLATENCY); i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign land_valid = valid_d[RLATENCY-1];
    assign land_tag   = tag_d[RLATENCY-1];
    assign land_data  = data_d[RLATENCY-1];
    assign out_valid  = valid_q[RLATENCY-1];
    assign out_tag    = tag_q[RLATENCY-1];
    assign out_data   = data_q[RLATENCY-1];

endmodule

// File: rtl/spu_gbuf_responder.sv
// Global feature-map buffer responder: 1R1W array shared by the SPU gbuf port and a
// host load/dump port, with an ownership FSM giving the SPU stall-free access.
// Build option SPU_GBUF_WR_BYPASS_EN: same-cycle write->read forwarding (write-first);
// without it a same-address read returns the old word (read-first).
module spu_gbuf_responder
    import spu_gbuf_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RLATENCY   = 1,
    parameter int unsigned DEPTH      = 4096
) (
    input  logic                 core_clk,
    input  logic                 rst_n,
    input  logic                 spu_start,
    input  logic                 spu_end,
    spu_gbuf_responder_if.slave  bus,
    output logic                 gbuf_busy,
    output logic                 addr_err
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    gbuf_state_e            state_q, state_d;
    logic [DRAIN_CNT_W-1:0] drain_cnt_q, drain_cnt_d;
    logic                   busy_q, busy_d;
    logic                   addr_err_q, addr_err_d;
    logic [DATA_WIDTH-1:0]  spu_rdata_q, spu_rdata_d;

    logic                   host_ready_c;
    logic                   host_acc_c;
    logic                   rd_en_c;
    logic                   rd_tag_c;
    logic [ADDR_WIDTH-1:0]  rd_addr_c;
    logic                   rd_ok_c;
    logic [DATA_WIDTH-1:0]  rd_data_c;
    logic                   wr_en_c;
    logic [ADDR_WIDTH-1:0]  wr_addr_c;
    logic [DATA_WIDTH-1:0]  wr_data_c;
    logic                   wr_ok_c;

    logic                   land_valid, land_tag;
    logic [DATA_WIDTH-1:0]  land_data;
    logic                   out_valid, out_tag;
    logic [DATA_WIDTH-1:0]  out_data;

    logic [DATA_WIDTH-1:0]  mem [DEPTH];

    // Host only while it owns the array, never in a spu_start cycle, and never on a
    // port the SPU is using this cycle.
    assign host_ready_c = (state_q == ST_HOST) && !spu_start
                        && !(bus.spu_gbuf_ren && !bus.host_req_we)
                        && !(bus.spu_gbuf_wen &&  bus.host_req_we);
    assign host_acc_c   = bus.host_req_valid && host_ready_c;

    // Port arbitration onto the single read and single write port; SPU always wins.
    always_comb begin
        rd_en_c   = bus.spu_gbuf_ren || (host_acc_c && !bus.host_req_we);
        rd_tag_c  = bus.spu_gbuf_ren ? TAG_SPU : TAG_HOST;
        rd_addr_c = bus.spu_gbuf_ren ? bus.spu_gbuf_raddr : bus.host_req_addr;
        wr_en_c   = bus.spu_gbuf_wen || (host_acc_c && bus.host_req_we);
        wr_addr_c = bus.spu_gbuf_wen ? bus.spu_gbuf_waddr : bus.host_req_addr;
        wr_data_c = bus.spu_gbuf_wen ? bus.spu_gbuf_wdata : bus.host_req_wdata;
        rd_ok_c   = addr_in_range(32'(rd_addr_c), DEPTH);
        wr_ok_c   = addr_in_range(32'(wr_addr_c), DEPTH);
    end

    // Issue-cycle array read; out-of-range reads return zero.
    always_comb begin
        rd_data_c = '0;
        if (rd_en_c && rd_ok_c) begin
            rd_data_c = mem[IDX_W'(rd_addr_c)];
        end
`ifdef SPU_GBUF_WR_BYPASS_EN
        if (rd_en_c && rd_ok_c && wr_en_c && wr_ok_c && (wr_addr_c == rd_addr_c)) begin
            rd_data_c = wr_data_c;
        end
`endif
    end

    // Array write; contents survive reset and out-of-range writes are dropped.
    always_ff @(posedge core_clk) begin
        if (wr_en_c && wr_ok_c) begin
            mem[IDX_W'(wr_addr_c)] <= wr_data_c;
        end
    end

    spu_gbuf_rd_pipe #(
        .RLATENCY   (RLATENCY),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rd_pipe (
        .core_clk   (core_clk),
        .rst_n      (rst_n),
        .in_valid   (rd_en_c),
        .in_tag     (rd_tag_c),
        .in_data    (rd_data_c),
        .land_valid (land_valid),
        .land_tag   (land_tag),
        .land_data  (land_data),
        .out_valid  (out_valid),
        .out_tag    (out_tag),
        .out_data   (out_data)
    );

    // Ownership FSM: leaves DRAIN on the edge where the counter reaches zero, so the
    // host regains the array exactly RLATENCY cycles after spu_end.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        unique case (state_q)
            ST_HOST: begin
                if (spu_start) begin
                    state_d = ST_SPU_ACT;
                end
            end
            ST_SPU_ACT: begin
                if (spu_end) begin
                    drain_cnt_d = DRAIN_CNT_W'(RLATENCY - 1);
                    state_d     = (RLATENCY > 1) ? ST_DRAIN : ST_HOST;
                end
            end
            ST_DRAIN: begin
                if (spu_start) begin
                    state_d     = ST_SPU_ACT;
                    drain_cnt_d = '0;
                end else begin
                    drain_cnt_d = drain_cnt_q - DRAIN_CNT_W'(1);
                    if (drain_cnt_d == '0) begin
                        state_d = ST_HOST;
                    end
                end
            end
            default: begin
                state_d     = ST_HOST;
                drain_cnt_d = '0;
            end
        endcase
    end

    // Output next-state: busy flag, sticky address error, held SPU read data.
    always_comb begin
        busy_d      = (state_d != ST_HOST);
        addr_err_d  = addr_err_q || (rd_en_c && !rd_ok_c) || (wr_en_c && !wr_ok_c);
        spu_rdata_d = spu_rdata_q;
        if (land_valid && (land_tag == TAG_SPU)) begin
            spu_rdata_d = land_data;
        end
    end

    // State and output registers.
    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_HOST;
            drain_cnt_q <= '0;
            busy_q      <= 1'b0;
            addr_err_q  <= 1'b0;
            spu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            busy_q      <= busy_d;
            addr_err_q  <= addr_err_d;
            spu_rdata_q <= spu_rdata_d;
        end
    end

    assign bus.host_req_ready = host_ready_c;
    assign bus.spu_gbuf_rdata = spu_rdata_q;
    assign bus.host_rsp_valid = out_valid && (out_tag == TAG_HOST);
    assign bus.host_rsp_rdata = out_data;
    assign gbuf_busy          = busy_q;
    assign addr_err           = addr_err_q;

endmodule
